// File: rtl/y_alu_seq_if.sv
// Request/response bundle between the EX-stage control unit and y_alu_seq.
// The master side issues start/op/a/b; the slave side returns the result
// registers and the busy/done handshake.
interface y_alu_seq_if #(
  parameter int SIZE = 32
);
  logic            start;
  logic [3:0]      op;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic [SIZE-1:0] z;
  logic [SIZE-1:0] zHi;
  logic            zero;
  logic            ex;
  logic            busy;
  logic            done;

  modport master (
    output start, op, a, b,
    input  z, zHi, zero, ex, busy, done
  );

  modport slave (
    input  start, op, a, b,
    output z, zHi, zero, ex, busy, done
  );
endinterface

// File: rtl/y_alu_seq.sv
// Multi-cycle ALU: single-cycle AND/OR/ADD/SUB/SLT plus iterative
// shift-add multiply and restoring divide (signed and unsigned).
// Signed iterative ops run on magnitudes; signs are fixed on the last step
// so the result registers load the corrected value when DONE is entered.
module y_alu_seq #(
  parameter int SIZE = 32
) (
  input logic        clk,
  input logic        rst,
  y_alu_seq_if.slave bus
);

  localparam int CW = $clog2(SIZE) + 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic [SIZE-1:0] hi_reg;      // product high half / partial remainder
  logic [SIZE-1:0] lo_reg;      // multiplier bits / dividend-into-quotient
  logic [SIZE-1:0] opnd_reg;    // multiplicand or divisor magnitude
  logic            is_div_reg;
  logic            neg_lo_reg;  // negate product, or negate quotient
  logic            neg_hi_reg;  // negate remainder (sign of dividend)
  logic [SIZE-1:0] z_reg, zhi_reg;
  logic            zero_reg, ex_reg;
  logic            busy_o, done_o;

  // Decode of the request currently on the bus
  logic is_iter, is_div, is_signed, div_by_zero, go_run, accept, last_step;
  assign is_iter     = bus.op[3] & ~bus.op[2];
  assign is_div      = is_iter & bus.op[1];
  assign is_signed   = bus.op[0];
  assign div_by_zero = is_div & (bus.b == '0);
  assign go_run      = is_iter & ~div_by_zero;
  assign accept      = bus.start & (state_reg != RUN);
  assign last_step   = (state_reg == RUN) && (cnt_reg == LAST);

  // Operand magnitudes; only meaningful for iterative ops
  logic            a_neg, b_neg;
  logic [SIZE-1:0] a_mag, b_mag;
  assign a_neg = is_signed & bus.a[SIZE-1];
  assign b_neg = is_signed & bus.b[SIZE-1];
  assign a_mag = a_neg ? (~bus.a + 1'b1) : bus.a;
  assign b_mag = b_neg ? (~bus.b + 1'b1) : bus.b;

  // Bitwise logic unit, one slice per bit
  logic [SIZE-1:0] and_v, or_v;
  for (genvar gi = 0; gi < SIZE; gi++) begin : g_logic
    assign and_v[gi] = bus.a[gi] & bus.b[gi];
    assign or_v[gi]  = bus.a[gi] | bus.b[gi];
  end

  // Single-cycle results: ALU ops, divide-by-zero and illegal codes.
  // MUL codes fall into the default arm but never use this path.
  logic [SIZE-1:0] alu_z, alu_zhi;
  logic            alu_ex;
  always_comb begin
    alu_z   = '0;
    alu_zhi = '0;
    alu_ex  = 1'b0;
    case (bus.op)
      4'b0000: alu_z = and_v;
      4'b0001: alu_z = or_v;
      4'b0010: alu_z = bus.a + bus.b;
      4'b0110: alu_z = bus.a - bus.b;
      4'b0111: alu_z = {{(SIZE-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      4'b1010, 4'b1011: begin
        alu_z   = '1;
        alu_zhi = bus.a;
        alu_ex  = 1'b1;
      end
      default: alu_ex = 1'b1;
    endcase
  end

  // One iteration step: shift-add for multiply, restoring subtract for divide
  logic [SIZE:0]   mul_sum, div_shift, div_diff;
  logic [SIZE-1:0] step_hi, step_lo;
  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : {(SIZE+1){1'b0}});
    div_shift = {hi_reg, lo_reg[SIZE-1]};
    div_diff  = div_shift - {1'b0, opnd_reg};
    step_hi   = mul_sum[SIZE:1];
    step_lo   = {mul_sum[0], lo_reg[SIZE-1:1]};
    if (is_div_reg) begin
      if (!div_diff[SIZE]) begin
        step_hi = div_diff[SIZE-1:0];
        step_lo = {lo_reg[SIZE-2:0], 1'b1};
      end else begin
        step_hi = div_shift[SIZE-1:0];
        step_lo = {lo_reg[SIZE-2:0], 1'b0};
      end
    end
  end

  // Sign correction applied to the outcome of the final step
  logic [2*SIZE-1:0] prod;
  logic [SIZE-1:0]   fin_z, fin_zhi;
  always_comb begin
    prod = {step_hi, step_lo};
    if (neg_lo_reg) begin
      prod = ~prod + 1'b1;
    end
    fin_z   = prod[SIZE-1:0];
    fin_zhi = prod[2*SIZE-1:SIZE];
    if (is_div_reg) begin
      fin_z   = neg_lo_reg ? (~step_lo + 1'b1) : step_lo;
      fin_zhi = neg_hi_reg ? (~step_hi + 1'b1) : step_hi;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state_reg;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) state_next = go_run ? RUN : DONE;
      end
      RUN: begin
        busy_o = 1'b1;
        if (cnt_reg == LAST) state_next = DONE;
      end
      DONE: begin
        done_o = 1'b1;
        if (bus.start) state_next = go_run ? RUN : DONE;
        else           state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      opnd_reg   <= '0;
      is_div_reg <= 1'b0;
      neg_lo_reg <= 1'b0;
      neg_hi_reg <= 1'b0;
      z_reg      <= '0;
      zhi_reg    <= '0;
      zero_reg   <= 1'b0;
      ex_reg     <= 1'b0;
    end else begin
      if (accept && go_run) begin
        cnt_reg    <= '0;
        hi_reg     <= '0;
        lo_reg     <= is_div ? a_mag : b_mag;
        opnd_reg   <= is_div ? b_mag : a_mag;
        is_div_reg <= is_div;
        neg_lo_reg <= a_neg ^ b_neg;
        neg_hi_reg <= a_neg;
      end else if (state_reg == RUN) begin
        cnt_reg <= cnt_reg + 1'b1;
        hi_reg  <= step_hi;
        lo_reg  <= step_lo;
      end

      if (accept && !go_run) begin
        z_reg    <= alu_z;
        zhi_reg  <= alu_zhi;
        zero_reg <= (alu_z == '0);
        ex_reg   <= alu_ex;
      end else if (last_step) begin
        z_reg    <= fin_z;
        zhi_reg  <= fin_zhi;
        zero_reg <= (fin_z == '0);
        ex_reg   <= 1'b0;
      end
    end
  end

  assign bus.z    = z_reg;
  assign bus.zHi  = zhi_reg;
  assign bus.zero = zero_reg;
  assign bus.ex   = ex_reg;
  assign bus.busy = busy_o;
  assign bus.done = done_o;

endmodule

// File: tb/tb_y_alu_seq.sv
// Directed bench for y_alu_seq at SIZE=32. Inputs change on the falling
// edge, outputs are sampled on the falling edge. Latency counts falling-edge
// samples after the accepting rising edge, so a single-cycle op reports 1 and
// an iterative op reports SIZE+1.
module tb_y_alu_seq;

  localparam int SIZE = 32;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   overlap;

  y_alu_seq_if #(.SIZE(SIZE)) bus ();

  y_alu_seq #(.SIZE(SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for done, counting samples and busy cycles.
  task automatic wait_done(input int lat_in, input int bcnt_in, output int lat, output int bcnt);
    lat  = lat_in;
    bcnt = bcnt_in;
    while (!bus.done && lat < 200) begin
      if (bus.busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (bus.busy && bus.done) overlap++;
  endtask

  // Drive a request at the current falling edge; return at the done sample.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bcnt);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    wait_done(1, 0, lat, bcnt);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] ez,
                        input logic [31:0] ezhi, input logic eex);
    int lat, bcnt;
    issue(op, a, b, lat, bcnt);
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busycyc"}, 64'(bcnt), 64'(exp_lat - 1));
    chk({tag, "_z"}, 64'(bus.z), 64'(ez));
    chk({tag, "_zhi"}, 64'(bus.zHi), 64'(ezhi));
    chk({tag, "_ex"}, 64'(bus.ex), 64'(eex));
    chk({tag, "_zero"}, 64'(bus.zero), 64'(ez == 32'd0));
    $display("op=%b a=%h b=%h -> z=%h zHi=%h zero=%b ex=%b lat=%0d",
             op, a, b, bus.z, bus.zHi, bus.zero, bus.ex, lat);
  endtask

  // One idle cycle after a result: done must have dropped.
  task automatic idle_gap(input string tag);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    chk({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int lat, bcnt, n;
    errors    = 0;
    checks    = 0;
    overlap   = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 4'b0000;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_z", 64'(bus.z), 64'd0);
    chk("rst_zhi", 64'(bus.zHi), 64'd0);
    chk("rst_zero", 64'(bus.zero), 64'd0);
    chk("rst_ex", 64'(bus.ex), 64'd0);
    $display("reset released");
    rst = 1'b0;
    @(negedge clk);

    // Iterative ops: latency SIZE+1, busy for SIZE sampled cycles
    run_op("mulu_max", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    idle_gap("mulu_max");
    run_op("mulu_carry", 4'b1000, 32'h0001_0000, 32'h0001_0000, 33, 32'h0, 32'h1, 1'b0);
    idle_gap("mulu_carry");
    run_op("muls_neg", 4'b1001, 32'hFFFF_FFFD, 32'd7, 33, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0);
    idle_gap("muls_neg");
    run_op("muls_negneg", 4'b1001, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 33, 32'd21, 32'd0, 1'b0);
    idle_gap("muls_negneg");
    run_op("divu", 4'b1010, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0);
    idle_gap("divu");
    run_op("divs_nega", 4'b1011, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    idle_gap("divs_nega");
    run_op("divs_negb", 4'b1011, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1, 1'b0);
    idle_gap("divs_negb");
    run_op("divs_ovf", 4'b1011, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0, 1'b0);
    idle_gap("divs_ovf");

    // Single-cycle paths
    run_op("divu_by0", 4'b1010, 32'h0000_1234, 32'd0, 1, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
    idle_gap("divu_by0");
    run_op("divs_by0", 4'b1011, 32'h8000_0005, 32'd0, 1, 32'hFFFF_FFFF, 32'h8000_0005, 1'b1);
    idle_gap("divs_by0");
    run_op("slt_true", 4'b0111, 32'hFFFF_FFFF, 32'd1, 1, 32'd1, 32'd0, 1'b0);
    idle_gap("slt_true");
    run_op("slt_false", 4'b0111, 32'd1, 32'hFFFF_FFFF, 1, 32'd0, 32'd0, 1'b0);
    idle_gap("slt_false");
    run_op("sub_eq", 4'b0110, 32'd5, 32'd5, 1, 32'd0, 32'd0, 1'b0);
    idle_gap("sub_eq");
    run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd2, 1, 32'd1, 32'd0, 1'b0);
    idle_gap("add_wrap");
    run_op("and", 4'b0000, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 1, 32'h00F0_A5A5, 32'd0, 1'b0);
    idle_gap("and");
    run_op("or", 4'b0001, 32'h0F00_0000, 32'h0000_00F0, 1, 32'h0F00_00F0, 32'd0, 1'b0);
    idle_gap("or");
    run_op("ill_0101", 4'b0101, 32'd9, 32'd3, 1, 32'd0, 32'd0, 1'b1);
    idle_gap("ill_0101");
    run_op("ill_1100", 4'b1100, 32'd9, 32'd3, 1, 32'd0, 32'd0, 1'b1);
    idle_gap("ill_1100");

    // Second start while busy is ignored
    bus.start = 1'b1;
    bus.op    = 4'b1000;
    bus.a     = 32'd3;
    bus.b     = 32'd5;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 4'b0010;
    bus.a     = 32'd1;
    bus.b     = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(6, 6, lat, bcnt);
    chk("ignore_done", 64'(bus.done), 64'd1);
    chk("ignore_lat", 64'(lat), 64'd33);
    chk("ignore_z", 64'(bus.z), 64'd15);
    chk("ignore_zhi", 64'(bus.zHi), 64'd0);
    $display("busy-start ignored: z=%h lat=%0d", bus.z, lat);
    idle_gap("ignore");

    // Reset in the middle of a run discards the result
    bus.start = 1'b1;
    bus.op    = 4'b1000;
    bus.a     = 32'd3;
    bus.b     = 32'd5;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_z", 64'(bus.z), 64'd0);
    chk("midrst_zhi", 64'(bus.zHi), 64'd0);
    chk("midrst_ex", 64'(bus.ex), 64'd0);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) n++;
    end
    chk("midrst_no_done", 64'(n), 64'd0);
    $display("reset mid-run: busy=%b done=%b z=%h", bus.busy, bus.done, bus.z);

    // Reset wins over a simultaneous start
    bus.start = 1'b1;
    bus.op    = 4'b0010;
    bus.a     = 32'd1;
    bus.b     = 32'd1;
    rst       = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    rst       = 1'b0;
    chk("rststart_done", 64'(bus.done), 64'd0);
    chk("rststart_busy", 64'(bus.busy), 64'd0);
    chk("rststart_z", 64'(bus.z), 64'd0);
    $display("start with reset: done=%b z=%h", bus.done, bus.z);
    @(negedge clk);

    // Back-to-back: new start in the DONE cycle
    run_op("b2b_first", 4'b1010, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0);
    run_op("b2b_second", 4'b1000, 32'd6, 32'd7, 33, 32'd42, 32'd0, 1'b0);
    run_op("b2b_alu", 4'b0010, 32'd40, 32'd2, 1, 32'd42, 32'd0, 1'b0);
    idle_gap("b2b");

    chk("busy_done_overlap", 64'(overlap), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
